// File: rtl/fk_seq_pkg.sv
// Shared types and angle limits for the forward-kinematics sequencer slice.
package fk_seq_pkg;

  localparam int unsigned ANGLE_W = 9;

  typedef logic signed [ANGLE_W-1:0] angle_t;

  localparam angle_t ANGLE_MIN = angle_t'(-180);
  localparam angle_t ANGLE_MAX = angle_t'(179);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } state_e;

endpackage

// File: rtl/fk_joint_sequencer_if.sv
// FK-engine bus plus captured-pose valid/ready channel of the sequencer.
interface fk_joint_sequencer_if;
  import fk_seq_pkg::*;

  angle_t      fk_th1;
  angle_t      fk_th2;
  logic        fk_enable;
  logic        fk_reset;
  logic        fk_data_ready;
  logic [63:0] fk_x;
  logic [63:0] fk_y;

  logic [63:0] pose_x;
  logic [63:0] pose_y;
  angle_t      pose_th1;
  angle_t      pose_th2;
  logic        pose_valid;
  logic        pose_ready;

  modport master (
    output fk_th1, fk_th2, fk_enable, fk_reset,
    input  fk_data_ready, fk_x, fk_y,
    output pose_x, pose_y, pose_th1, pose_th2, pose_valid,
    input  pose_ready
  );

  modport slave (
    input  fk_th1, fk_th2, fk_enable, fk_reset,
    output fk_data_ready, fk_x, fk_y,
    input  pose_x, pose_y, pose_th1, pose_th2, pose_valid,
    output pose_ready
  );
endinterface

// File: rtl/fk_joint_sequencer_step.sv
// Per-joint microstep accumulator: signed whole-degree angle plus sub-degree count.
module joint_step_accum
  import fk_seq_pkg::*;
#(
  parameter int unsigned STEPS_PER_DEG = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  input  logic   dir,
  input  logic   home,
  input  angle_t home_angle,
  output angle_t angle,
  output logic   changed
);

  localparam int unsigned SUB_W = $clog2(STEPS_PER_DEG);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(STEPS_PER_DEG - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  angle_t           angle_q, angle_d;

  always_comb begin
    sub_d   = sub_q;
    angle_d = angle_q;
    if (home) begin
      sub_d   = '0;
      angle_d = home_angle;
    end else if (step) begin
      if (dir) begin
        if (sub_q == SUB_MAX) begin
          sub_d   = '0;
          angle_d = (angle_q == ANGLE_MAX) ? ANGLE_MIN : angle_q + angle_t'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end else begin
        if (sub_q == '0) begin
          sub_d   = SUB_MAX;
          angle_d = (angle_q == ANGLE_MIN) ? ANGLE_MAX : angle_q - angle_t'(1);
        end else begin
          sub_d = sub_q - SUB_W'(1);
        end
      end
    end
  end

  // home always requests a recompute, even when the angle is already home
  assign changed = home || (angle_d != angle_q);
  assign angle   = angle_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sub_q   <= '0;
      angle_q <= '0;
    end else begin
      sub_q   <= sub_d;
      angle_q <= angle_d;
    end
  end

endmodule

// File: rtl/fk_joint_sequencer.sv
// Step-accumulating front end that launches FK computations and hands poses to the host.
module fk_joint_sequencer
  import fk_seq_pkg::*;
#(
  parameter int unsigned STEPS_PER_DEG = 16,
  parameter int unsigned FK_TIMEOUT    = 64,
  parameter angle_t      HOME_TH1      = '0,
  parameter angle_t      HOME_TH2      = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step1,
  input  logic                        dir1,
  input  logic                        step2,
  input  logic                        dir2,
  input  logic                        home,
  input  logic                        refresh,
  fk_joint_sequencer_if.master        sif,
  output logic                        busy,
  output logic                        fk_error
);

  localparam int unsigned TMO_W = (FK_TIMEOUT > 2) ? $clog2(FK_TIMEOUT) : 1;

  angle_t angle1, angle2;
  logic   chg1, chg2;

  joint_step_accum #(.STEPS_PER_DEG(STEPS_PER_DEG)) u_joint1 (
    .clk        (clk),
    .reset      (reset),
    .step       (step1),
    .dir        (dir1),
    .home       (home),
    .home_angle (HOME_TH1),
    .angle      (angle1),
    .changed    (chg1)
  );

  joint_step_accum #(.STEPS_PER_DEG(STEPS_PER_DEG)) u_joint2 (
    .clk        (clk),
    .reset      (reset),
    .step       (step2),
    .dir        (dir2),
    .home       (home),
    .home_angle (HOME_TH2),
    .angle      (angle2),
    .changed    (chg2)
  );

  state_e             state_q, state_d;
  logic               dirty_q, dirty_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  angle_t             fk_th1_q, fk_th1_d, fk_th2_q, fk_th2_d;
  logic               fk_en_q, fk_en_d, fk_rst_q, fk_rst_d;
  logic [63:0]        pose_x_q, pose_x_d, pose_y_q, pose_y_d;
  angle_t             pose_th1_q, pose_th1_d, pose_th2_q, pose_th2_d;
  logic               pose_valid_q, pose_valid_d;
  logic               fk_error_q, fk_error_d;

  always_comb begin
    state_d      = state_q;
    dirty_d      = dirty_q;
    tmo_d        = tmo_q;
    fk_th1_d     = fk_th1_q;
    fk_th2_d     = fk_th2_q;
    fk_en_d      = fk_en_q;
    fk_rst_d     = fk_rst_q;
    pose_x_d     = pose_x_q;
    pose_y_d     = pose_y_q;
    pose_th1_d   = pose_th1_q;
    pose_th2_d   = pose_th2_q;
    pose_valid_d = pose_valid_q;
    fk_error_d   = fk_error_q;

    if (pose_valid_q && sif.pose_ready) pose_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        fk_rst_d = 1'b1;
        fk_en_d  = 1'b0;
        if (dirty_q && (!pose_valid_q || sif.pose_ready)) state_d = CLEAR;
      end
      CLEAR: begin
        fk_th1_d = angle1;
        fk_th2_d = angle2;
        dirty_d  = 1'b0;
        tmo_d    = '0;
        fk_rst_d = 1'b0;
        fk_en_d  = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (sif.fk_data_ready) begin
          pose_x_d     = sif.fk_x;
          pose_y_d     = sif.fk_y;
          pose_th1_d   = fk_th1_q;
          pose_th2_d   = fk_th2_q;
          pose_valid_d = 1'b1;
          fk_rst_d     = 1'b1;
          fk_en_d      = 1'b0;
          state_d      = IDLE;
        end else if (tmo_q == TMO_W'(FK_TIMEOUT - 1)) begin
          fk_error_d = 1'b1;
          dirty_d    = 1'b1;
          fk_rst_d   = 1'b1;
          fk_en_d    = 1'b0;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        fk_rst_d = 1'b1;
        fk_en_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // applied after the CLEAR snapshot so a change landing in that cycle is not lost
    if (chg1 || chg2 || refresh) dirty_d = 1'b1;
    if (home) fk_error_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      dirty_q      <= 1'b1;
      tmo_q        <= '0;
      fk_th1_q     <= '0;
      fk_th2_q     <= '0;
      fk_en_q      <= 1'b0;
      fk_rst_q     <= 1'b1;
      pose_x_q     <= '0;
      pose_y_q     <= '0;
      pose_th1_q   <= '0;
      pose_th2_q   <= '0;
      pose_valid_q <= 1'b0;
      fk_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dirty_q      <= dirty_d;
      tmo_q        <= tmo_d;
      fk_th1_q     <= fk_th1_d;
      fk_th2_q     <= fk_th2_d;
      fk_en_q      <= fk_en_d;
      fk_rst_q     <= fk_rst_d;
      pose_x_q     <= pose_x_d;
      pose_y_q     <= pose_y_d;
      pose_th1_q   <= pose_th1_d;
      pose_th2_q   <= pose_th2_d;
      pose_valid_q <= pose_valid_d;
      fk_error_q   <= fk_error_d;
    end
  end

  assign sif.fk_th1     = fk_th1_q;
  assign sif.fk_th2     = fk_th2_q;
  assign sif.fk_enable  = fk_en_q;
  assign sif.fk_reset   = fk_rst_q;
  assign sif.pose_x     = pose_x_q;
  assign sif.pose_y     = pose_y_q;
  assign sif.pose_th1   = pose_th1_q;
  assign sif.pose_th2   = pose_th2_q;
  assign sif.pose_valid = pose_valid_q;
  assign busy           = (state_q == CLEAR) || (state_q == RUN);
  assign fk_error       = fk_error_q;

endmodule
